// File: rtl/motor_io.sv
// Memory-mapped IO peripheral on the darkriscv data bus that drives motor_driver.
// Holds the control/speed/LED registers, runs the move-N-steps sequencer and tracks position.
module motor_io #(
    parameter logic [31:0] BASE_ADDR   = 32'h10000000,
    parameter int          SPEED_WIDTH = 16,
    parameter int unsigned SPEED_RESET = 75
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic [31:0]            addr_in,
    input  logic [31:0]            data_in,
    input  logic [3:0]             byte_en_in,
    input  logic                   write_in,
    input  logic                   read_in,
    output logic [31:0]            data_out,
    input  logic                   step_in,
    output logic [SPEED_WIDTH-1:0] speed_out,
    output logic                   step_enable_out,
    output logic                   direction_out,
    output logic                   driver_en_out,
    output logic [7:0]             led_out
);

    localparam logic [5:0] REG_CTRL   = 6'd0;
    localparam logic [5:0] REG_SPEED  = 6'd1;
    localparam logic [5:0] REG_MOVE   = 6'd2;
    localparam logic [5:0] REG_STATUS = 6'd3;
    localparam logic [5:0] REG_POS    = 6'd4;
    localparam logic [5:0] REG_LED    = 6'd5;

    typedef enum logic [1:0] {IDLE, MOVING, DONE} state_t;

    state_t                 state;
    logic [2:0]             ctrl;
    logic [SPEED_WIDTH-1:0] speed;
    logic [31:0]            remaining;
    logic [31:0]            position;
    logic [7:0]             led;
    logic                   done_flag;
    logic                   abort_flag;
    logic                   move_dir;
    logic                   step_q;

    logic        hit;
    logic        wr;
    logic [5:0]  offset;
    logic [31:0] wmask;
    logic [2:0]  ctrl_next;
    logic        ctrl_wr;
    logic        speed_wr;
    logic        move_wr;
    logic        status_wr;
    logic        pos_wr;
    logic        led_wr;
    logic        step_edge;
    logic [31:0] rdata;
    logic        unused_ok;

    assign hit       = (addr_in[31:8] == BASE_ADDR[31:8]);
    assign wr        = write_in & ~read_in & hit;
    assign offset    = addr_in[7:2];
    assign wmask     = {{8{byte_en_in[3]}}, {8{byte_en_in[2]}}, {8{byte_en_in[1]}}, {8{byte_en_in[0]}}};
    assign ctrl_next = (ctrl & ~wmask[2:0]) | (data_in[2:0] & wmask[2:0]);
    assign ctrl_wr   = wr && (offset == REG_CTRL);
    assign speed_wr  = wr && (offset == REG_SPEED);
    assign move_wr   = wr && (offset == REG_MOVE) && (byte_en_in == 4'b1111);
    assign status_wr = wr && (offset == REG_STATUS);
    assign pos_wr    = wr && (offset == REG_POS);
    assign led_wr    = wr && (offset == REG_LED);
    assign step_edge = step_in & ~step_q;
    assign unused_ok = &{1'b0, addr_in[1:0]};

    assign speed_out       = speed;
    assign led_out         = led;
    assign driver_en_out   = ctrl[0];
    assign direction_out   = (state == IDLE) ? ctrl[1] : move_dir;
    assign step_enable_out = (state == MOVING) || ((state == IDLE) && ctrl[0] && ctrl[2]);

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (offset)
                REG_CTRL:   rdata = {29'd0, ctrl};
                REG_SPEED:  rdata = 32'(speed);
                REG_MOVE:   rdata = remaining;
                REG_STATUS: rdata = {29'd0, abort_flag, done_flag, (state == MOVING)};
                REG_POS:    rdata = position;
                REG_LED:    rdata = {24'd0, led};
                default:    rdata = 32'd0;
            endcase
        end
    end

    // Sticky flag sets are written after the W1C clears so a coincident set wins.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state      <= IDLE;
            ctrl       <= 3'd0;
            speed      <= SPEED_WIDTH'(SPEED_RESET);
            remaining  <= 32'd0;
            position   <= 32'd0;
            led        <= 8'd0;
            done_flag  <= 1'b0;
            abort_flag <= 1'b0;
            move_dir   <= 1'b0;
            step_q     <= 1'b0;
            data_out   <= 32'd0;
        end else begin
            step_q <= step_in;
            if (read_in) begin
                data_out <= rdata;
            end
            if (ctrl_wr) begin
                ctrl <= ctrl_next;
            end
            if (speed_wr) begin
                speed <= (speed & ~wmask[SPEED_WIDTH-1:0]) | (data_in[SPEED_WIDTH-1:0] & wmask[SPEED_WIDTH-1:0]);
            end
            if (led_wr) begin
                led <= (led & ~wmask[7:0]) | (data_in[7:0] & wmask[7:0]);
            end
            if (pos_wr) begin
                position <= (position & ~wmask) | (data_in & wmask);
            end else if (step_edge && ctrl[0]) begin
                position <= direction_out ? position - 32'd1 : position + 32'd1;
            end
            if (status_wr) begin
                if (data_in[1]) done_flag <= 1'b0;
                if (data_in[2]) abort_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (move_wr && (data_in != 32'd0) && ctrl[0]) begin
                        state     <= MOVING;
                        remaining <= data_in;
                        move_dir  <= ctrl[1];
                    end
                end
                MOVING: begin
                    if (ctrl_wr && !ctrl_next[0]) begin
                        state      <= IDLE;
                        remaining  <= 32'd0;
                        abort_flag <= 1'b1;
                    end else if (step_edge) begin
                        if (remaining == 32'd1) begin
                            remaining <= 32'd0;
                            state     <= DONE;
                        end else begin
                            remaining <= remaining - 32'd1;
                        end
                    end
                end
                DONE: begin
                    done_flag <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_io.sv
// Scoreboard bench for motor_io: bus reads queue their expected data, a monitor checks data_out.
module tb_motor_io;

    localparam logic [31:0] BASE   = 32'h10000000;
    localparam logic [31:0] CTRL   = BASE + 32'h00;
    localparam logic [31:0] SPEED  = BASE + 32'h04;
    localparam logic [31:0] MOVE   = BASE + 32'h08;
    localparam logic [31:0] STATUS = BASE + 32'h0C;
    localparam logic [31:0] POS    = BASE + 32'h10;
    localparam logic [31:0] LED    = BASE + 32'h14;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic [3:0]  byte_en_in = 4'd0;
    logic        write_in = 1'b0;
    logic        read_in = 1'b0;
    logic        step_in = 1'b0;
    logic [31:0] data_out;
    logic [15:0] speed_out;
    logic        step_enable_out;
    logic        direction_out;
    logic        driver_en_out;
    logic [7:0]  led_out;

    int          checks = 0;
    int          failures = 0;
    string       nameQ[$];
    logic [31:0] expQ[$];
    logic        readValid = 1'b0;

    motor_io dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .addr_in(addr_in),
        .data_in(data_in),
        .byte_en_in(byte_en_in),
        .write_in(write_in),
        .read_in(read_in),
        .data_out(data_out),
        .step_in(step_in),
        .speed_out(speed_out),
        .step_enable_out(step_enable_out),
        .direction_out(direction_out),
        .driver_en_out(driver_en_out),
        .led_out(led_out)
    );

    always #20 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One bus/step cycle, driven 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                                 input logic w, input logic r, input logic s);
        addr_in    = a;
        data_in    = d;
        byte_en_in = be;
        write_in   = w;
        read_in    = r;
        step_in    = s;
        @(posedge clk_in);
        #1;
        write_in = 1'b0;
        read_in  = 1'b0;
        step_in  = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        applyStimulus(a, d, be, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic busRead(input logic [31:0] a, input logic [31:0] expected, input string name);
        nameQ.push_back(name);
        expQ.push_back(expected);
        applyStimulus(a, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic stepPulse();
        applyStimulus(BASE, 32'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(BASE, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(posedge clk_in) readValid <= read_in;

    // Monitor: one registered read result appears per read cycle.
    always @(negedge clk_in) begin
        if (readValid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read data", data_out);
            end else begin
                checkOutput(nameQ.pop_front(), data_out, expQ.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset_n_in = 1'b1;
        checkOutput("reset_speed", 32'(speed_out), 32'd75);
        checkOutput("reset_step_en", 32'(step_enable_out), 32'd0);
        checkOutput("reset_dir", 32'(direction_out), 32'd0);
        checkOutput("reset_drv_en", 32'(driver_en_out), 32'd0);
        checkOutput("reset_led", 32'(led_out), 32'd0);
        checkOutput("reset_data_out", data_out, 32'd0);
        busRead(STATUS, 32'd0, "reset_status");

        busWrite(CTRL, 32'h1, 4'hF);
        busWrite(MOVE, 32'd3, 4'hF);
        checkOutput("move_drv_en", 32'(driver_en_out), 32'd1);
        checkOutput("move_step_en", 32'(step_enable_out), 32'd1);
        checkOutput("move_dir", 32'(direction_out), 32'd0);
        busRead(STATUS, 32'h1, "move_busy");
        stepPulse();
        busRead(MOVE, 32'd2, "move_remaining");
        stepPulse();
        checkOutput("move_step_en_mid", 32'(step_enable_out), 32'd1);
        stepPulse();
        checkOutput("move_step_en_end", 32'(step_enable_out), 32'd0);
        busRead(STATUS, 32'h2, "move_done");
        busRead(POS, 32'd3, "move_pos");
        busRead(MOVE, 32'd0, "move_readback");

        busWrite(STATUS, 32'h2, 4'hF);
        busWrite(POS, 32'd0, 4'hF);
        busWrite(CTRL, 32'h3, 4'hF);
        busWrite(MOVE, 32'd5, 4'hF);
        checkOutput("abort_dir", 32'(direction_out), 32'd1);
        checkOutput("abort_step_en_run", 32'(step_enable_out), 32'd1);
        stepPulse();
        stepPulse();
        busWrite(CTRL, 32'h0, 4'hF);
        checkOutput("abort_step_en", 32'(step_enable_out), 32'd0);
        checkOutput("abort_drv_en", 32'(driver_en_out), 32'd0);
        busRead(STATUS, 32'h4, "abort_status");
        busRead(POS, 32'hFFFFFFFE, "abort_pos");
        busRead(MOVE, 32'd0, "abort_remaining");

        busWrite(STATUS, 32'h4, 4'hF);
        busWrite(LED, 32'hA5A5A5A5, 4'b0001);
        checkOutput("led_byte", 32'(led_out), 32'hA5);
        busWrite(CTRL, 32'h1, 4'hF);
        busWrite(MOVE, 32'd7, 4'b0011);
        checkOutput("move_partial_be", 32'(step_enable_out), 32'd0);
        busRead(STATUS, 32'h0, "partial_be_status");
        busWrite(MOVE, 32'd0, 4'hF);
        busRead(STATUS, 32'h0, "move_zero_status");
        busWrite(32'h20000014, 32'hFF, 4'hF);
        busWrite(32'h20000000, 32'h0, 4'hF);
        checkOutput("miss_led", 32'(led_out), 32'hA5);
        checkOutput("miss_drv_en", 32'(driver_en_out), 32'd1);
        busRead(32'h20000014, 32'd0, "miss_read");
        busRead(BASE + 32'h18, 32'd0, "unmapped_read");

        busWrite(SPEED, 32'h12345678, 4'b0010);
        checkOutput("speed_byte", 32'(speed_out), 32'h564B);
        busWrite(CTRL, 32'h5, 4'hF);
        checkOutput("cont_step_en", 32'(step_enable_out), 32'd1);
        busWrite(POS, 32'h7FFFFFFF, 4'hF);
        stepPulse();
        busRead(POS, 32'h80000000, "pos_wrap");
        applyStimulus(POS, 32'd10, 4'hF, 1'b1, 1'b0, 1'b1);
        applyStimulus(BASE, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        busRead(POS, 32'd10, "pos_write_wins");
        stepPulse();
        busRead(POS, 32'd11, "pos_after_write");
        busWrite(CTRL, 32'h1, 4'hF);

        busWrite(MOVE, 32'd4, 4'hF);
        busRead(STATUS, 32'h1, "pre_reset_busy");
        busRead(MOVE, 32'd4, "pre_reset_remaining");
        reset_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        reset_n_in = 1'b1;
        checkOutput("midreset_step_en", 32'(step_enable_out), 32'd0);
        checkOutput("midreset_drv_en", 32'(driver_en_out), 32'd0);
        checkOutput("midreset_speed", 32'(speed_out), 32'd75);
        busRead(STATUS, 32'h0, "midreset_status");
        busRead(MOVE, 32'd0, "midreset_remaining");
        busRead(POS, 32'd0, "midreset_pos");

        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_io.md
Name: motor_io

Overview:
Memory-mapped IO peripheral between the darkriscv data bus (IO region at 0x10000000) and motor_driver. It holds the control, speed and LED registers and drives motor_driver's speed_in and step_enable_in. It runs a move-N-steps state machine that counts motor_driver's step_out pulses and keeps a signed position counter. The CPU polls or clears status over the bus.

Parameters:
BASE_ADDR, 32'h10000000, IO region base; decode compares addr_in[31:8] against BASE_ADDR[31:8].
SPEED_WIDTH, 16, width of speed_out.
SPEED_RESET, 75, reset value of the SPEED register.

Ports:
clk_in  input  1  system clock (25 MHz)
reset_n_in  input  1  synchronous, active-low reset
addr_in  input  32  CPU data address (DADDR)
data_in  input  32  CPU write data (DATAO)
byte_en_in  input  4  CPU byte enables (BE)
write_in  input  1  CPU write strobe (WR)
read_in  input  1  CPU read strobe (RD)
data_out  output  32  registered read data to CPU
step_in  input  1  step_out feedback from motor_driver, same clock domain
speed_out  output  SPEED_WIDTH  to motor_driver speed_in
step_enable_out  output  1  to motor_driver step_enable_in
direction_out  output  1  direction pin (gp[1])
driver_en_out  output  1  driver enable pin (gp[2])
led_out  output  8  board LEDs

Behaviour:
- Clock and reset: one clock, clk_in. reset_n_in is synchronous and active-low.
- Reset values: data_out=0, speed_out=SPEED_RESET, step_enable_out=0, direction_out=0, driver_en_out=0, led_out=0. All registers are 0 except SPEED. FSM resets to IDLE.
- Register map (word offset = addr_in[7:2]):
  - 0x00 CTRL: bit0 DRV_EN, bit1 DIR, bit2 CONT (continuous run).
  - 0x04 SPEED: bits [SPEED_WIDTH-1:0].
  - 0x08 MOVE: write N starts a move; read returns remaining steps.
  - 0x0C STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 ABORT (sticky, W1C).
  - 0x10 POSITION: signed 32-bit.
  - 0x14 LED: bits [7:0].
- Access rules:
  - A write is write_in & ~read_in & decode hit.
  - Byte enables are honoured per byte on CTRL, SPEED, POSITION and LED.
  - MOVE writes are accepted only with byte_en_in=4'b1111; any other byte enable value is ignored.
  - Unmapped offsets or a decode miss: writes are dropped; reads return 0.
- Read latency: data_out updates exactly 1 cycle after the read_in cycle, then holds until the next read.
- Outputs:
  - driver_en_out = CTRL.DRV_EN.
  - direction_out = CTRL.DIR in IDLE; equals the latched move direction in MOVING and DONE.
- Step edge detection: step_q registers step_in; edge = step_in & ~step_q (1-cycle detection latency).
  - Each edge while driver_en_out=1 moves POSITION by +1 if direction_out=0, -1 if 1.
  - POSITION wraps modulo 2^32.
- FSM:
  - IDLE: step_enable_out = DRV_EN & CONT.
    - MOVE write with N!=0 and DRV_EN=1 -> MOVING; latch remaining=N and the direction.
    - MOVE write with N=0, or with DRV_EN=0, is ignored.
  - MOVING: step_enable_out=1, BUSY=1.
    - Each edge decrements remaining.
    - An edge with remaining==1 sets remaining=0 and goes to DONE.
    - CTRL write with DRV_EN=0 -> IDLE in the next cycle; remaining=0; ABORT set; DONE not set.
    - MOVE writes are ignored. CONT is ignored.
  - DONE (one cycle): step_enable_out=0, set DONE -> IDLE.
- Simultaneous events:
  - POSITION write in the same cycle as an edge: the write wins and the edge is not counted.
  - W1C of DONE in the same cycle the FSM sets DONE: the set wins.
  - DRV_EN cleared in the same cycle as the final edge: treated as abort, but the step is still counted in POSITION.
- Reset mid-move forces IDLE with all counters cleared on the next edge of clk_in.

Test Plan:
- Reset with reset_n_in=0 for 2 cycles -> speed_out=75, all other outputs 0; read of 0x0C returns 0 one cycle later.
- Write CTRL=0x1, then MOVE=3, DIR=0; pulse step_in 3 times -> step_enable_out=1 until 1 cycle after the 3rd edge, POSITION=3, STATUS=0x2, MOVE readback 0.
- Write CTRL=0x3, MOVE=5; 2 edges, then write CTRL=0x0 -> IDLE, STATUS=0x4, POSITION=-2 (0xFFFFFFFE), step_enable_out=0, driver_en_out=0.
- Write LED with data 0xA5A5A5A5, byte_en=4'b0001 -> led_out=0xA5. Write MOVE with byte_en=4'b0011 -> no move. Write to 0x20000000 -> no register changes.
- Write POSITION=0x7FFFFFFF in CONT mode (CTRL=0x5); 1 edge -> POSITION=0x80000000. Write POSITION=10 coincident with an edge -> POSITION=10.
- Assert reset_n_in mid-move (remaining=4) -> next cycle FSM in IDLE, remaining=0, BUSY=0, step_enable_out=0.
